// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU op encodings, opcode constants and the decoded-control record for the
// ID/EX issue register.
package alu_issue_stage_pkg;

   localparam int DATA_W = 16;

   localparam logic [3:0] OP_ROL = 4'd0;
   localparam logic [3:0] OP_SLL = 4'd1;
   localparam logic [3:0] OP_ROR = 4'd2;
   localparam logic [3:0] OP_SRL = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;

   localparam logic [4:0] OPC_ADDI     = 5'b01000;
   localparam logic [4:0] OPC_SUBI     = 5'b01001;
   localparam logic [4:0] OPC_XORI     = 5'b01010;
   localparam logic [4:0] OPC_ANDNI    = 5'b01011;
   localparam logic [4:0] OPC_RR_SHIFT = 5'b11010;
   localparam logic [4:0] OPC_RR_ARITH = 5'b11011;
   localparam logic [4:0] OPC_SEQ      = 5'b11100;
   localparam logic [4:0] OPC_SLT      = 5'b11101;
   localparam logic [4:0] OPC_SLE      = 5'b11110;
   localparam logic [4:0] OPC_SCO      = 5'b11111;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              cin;
      logic [3:0]        op;
      logic              inv_a;
      logic              inv_b;
      logic              sign;
      logic              alu_en;
   } alu_ctrl_t;

   function automatic logic [DATA_W-1:0] sext5(input logic [4:0] imm);
      return {{(DATA_W-5){imm[4]}}, imm};
   endfunction

   function automatic logic [DATA_W-1:0] zext5(input logic [4:0] imm);
      return {{(DATA_W-5){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_stage_ctrl_dec.sv
// Combinational decode of one instruction word plus Rs/Rt into the ALU operand and
// control bundle; no arithmetic, only operand selection.
module alu_ctrl_dec
   import alu_issue_stage_pkg::*;
(
   input  logic [DATA_W-1:0] instr,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output alu_ctrl_t         ctrl
);

   logic [4:0] opcode_s;
   logic [1:0] funct_s;
   logic [4:0] imm5_s;
   logic       unused_s;

   assign opcode_s = instr[15:11];
   assign funct_s  = instr[1:0];
   assign imm5_s   = instr[4:0];
   assign unused_s = ^instr[10:5];

   // Instruction decode; unknown opcodes fall through as a NOP with zeroed operands.
   always_comb begin
      ctrl        = '0;
      ctrl.op     = OP_ADD;
      casez (opcode_s)
         OPC_ADDI: begin
            ctrl = '{a: rs, b: sext5(imm5_s), cin: 1'b0, op: OP_ADD,
                     inv_a: 1'b0, inv_b: 1'b0, sign: 1'b1, alu_en: 1'b1};
         end
         OPC_SUBI: begin
            ctrl = '{a: rs, b: sext5(imm5_s), cin: 1'b1, op: OP_ADD,
                     inv_a: 1'b1, inv_b: 1'b0, sign: 1'b1, alu_en: 1'b1};
         end
         OPC_XORI: begin
            ctrl = '{a: rs, b: zext5(imm5_s), cin: 1'b0, op: OP_XOR,
                     inv_a: 1'b0, inv_b: 1'b0, sign: 1'b0, alu_en: 1'b1};
         end
         OPC_ANDNI: begin
            ctrl = '{a: rs, b: zext5(imm5_s), cin: 1'b0, op: OP_AND,
                     inv_a: 1'b0, inv_b: 1'b1, sign: 1'b0, alu_en: 1'b1};
         end
         5'b101??: begin
            // Shift-by-immediate: the low opcode bits line up with the shift op codes.
            ctrl = '{a: rs, b: {12'b0, imm5_s[3:0]}, cin: 1'b0, op: {2'b00, opcode_s[1:0]},
                     inv_a: 1'b0, inv_b: 1'b0, sign: 1'b0, alu_en: 1'b1};
         end
         OPC_RR_SHIFT: begin
            ctrl = '{a: rs, b: rt, cin: 1'b0, op: {2'b00, funct_s},
                     inv_a: 1'b0, inv_b: 1'b0, sign: 1'b0, alu_en: 1'b1};
         end
         OPC_RR_ARITH: begin
            ctrl.a      = rs;
            ctrl.b      = rt;
            ctrl.alu_en = 1'b1;
            case (funct_s)
               2'b00: begin
                  ctrl.op   = OP_ADD;
                  ctrl.sign = 1'b1;
               end
               2'b01: begin
                  ctrl.op    = OP_ADD;
                  ctrl.inv_a = 1'b1;
                  ctrl.cin   = 1'b1;
                  ctrl.sign  = 1'b1;
               end
               2'b10: begin
                  ctrl.op = OP_XOR;
               end
               2'b11: begin
                  ctrl.op    = OP_AND;
                  ctrl.inv_b = 1'b1;
               end
               default: begin
                  ctrl.op = OP_ADD;
               end
            endcase
         end
         OPC_SEQ, OPC_SLT, OPC_SLE: begin
            ctrl = '{a: rs, b: rt, cin: 1'b1, op: OP_ADD,
                     inv_a: 1'b0, inv_b: 1'b1, sign: 1'b1, alu_en: 1'b1};
         end
         OPC_SCO: begin
            ctrl = '{a: rs, b: rt, cin: 1'b0, op: OP_ADD,
                     inv_a: 1'b0, inv_b: 1'b0, sign: 1'b0, alu_en: 1'b1};
         end
         default: begin
            ctrl        = '0;
            ctrl.op     = OP_ADD;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX boundary register driving the ALU operand/control inputs, with valid/ready
// backpressure and branch-squash flush; one cycle of latency.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_instr,
   input  logic [WIDTH-1:0] in_rs,
   input  logic [WIDTH-1:0] in_rt,
   input  logic             flush,
   input  logic             ex_ready,
   output logic             ex_valid,
   output logic             ex_alu_en,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             Cin,
   output logic [3:0]       Op,
   output logic             invA,
   output logic             invB,
   output logic             sign
);

   alu_ctrl_t ctrl_s;
   alu_ctrl_t entry_r;
   logic      ex_valid_r;
   logic      accept_s;

   alu_ctrl_dec u_dec (
      .instr (in_instr),
      .rs    (in_rs),
      .rt    (in_rt),
      .ctrl  (ctrl_s)
   );

   assign in_ready = ~ex_valid_r | ex_ready;
   assign accept_s = in_valid & in_ready & ~flush;

   // Entry register: flush beats accept, accept beats drain; otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_r <= 1'b0;
         entry_r    <= '0;
      end else if (flush) begin
         ex_valid_r <= 1'b0;
      end else if (accept_s) begin
         ex_valid_r <= 1'b1;
         entry_r    <= ctrl_s;
      end else if (ex_ready) begin
         ex_valid_r <= 1'b0;
      end else begin
         ex_valid_r <= ex_valid_r;
      end
   end

   assign ex_valid  = ex_valid_r;
   assign ex_alu_en = entry_r.alu_en;
   assign A         = entry_r.a;
   assign B         = entry_r.b;
   assign Cin       = entry_r.cin;
   assign Op        = entry_r.op;
   assign invA      = entry_r.inv_a;
   assign invB      = entry_r.inv_b;
   assign sign      = entry_r.sign;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus random bench for alu_issue_stage; expected values come from the ISA
// meaning of each instruction evaluated through a reference ALU.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [15:0] in_rs;
   logic [15:0] in_rt;
   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   logic        ex_alu_en;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic [3:0]  Op;
   logic        invA;
   logic        invB;
   logic        sign;

   int n_checks = 0;
   int n_fail   = 0;

   // reference entry state
   bit          m_valid;
   logic [15:0] m_instr;
   logic [15:0] m_rs;
   logic [15:0] m_rt;

   alu_issue_stage #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt), .flush(flush),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_en(ex_alu_en),
      .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural ALU: ROL=0 SLL=1 ROR=2 SRL=3 ADD=4 AND=5 OR=6 XOR=7.
   function automatic logic [15:0] alu_eval(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic [3:0] op,
                                            input logic ia, input logic ib);
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] d;
      int          s;
      x = ia ? ~a : a;
      y = ib ? ~b : b;
      s = int'(y[3:0]);
      d = {x, x};
      case (op)
         4'd0:    alu_eval = 16'((d << s) >> 16);
         4'd1:    alu_eval = x << s;
         4'd2:    alu_eval = 16'(d >> s);
         4'd3:    alu_eval = x >> s;
         4'd4:    alu_eval = x + y + {15'd0, cin};
         4'd5:    alu_eval = x & y;
         4'd6:    alu_eval = x | y;
         4'd7:    alu_eval = x ^ y;
         default: alu_eval = 16'hxxxx;
      endcase
   endfunction

   function automatic logic [15:0] shift_ref(input logic [15:0] x, input logic [1:0] k, input int s);
      logic [15:0] r;
      r = x;
      for (int i = 0; i < s; i++) begin
         case (k)
            2'd0:    r = {r[14:0], r[15]};
            2'd1:    r = {r[14:0], 1'b0};
            2'd2:    r = {r[0], r[15:1]};
            default: r = {1'b0, r[15:1]};
         endcase
      end
      return r;
   endfunction

   // Intended ALU result of each instruction, from the ISA description.
   function automatic logic [15:0] ref_result(input logic [15:0] ins, input logic [15:0] rs,
                                              input logic [15:0] rt);
      logic [4:0]  opc;
      logic [15:0] sx;
      logic [15:0] zx;
      opc = ins[15:11];
      sx  = {{11{ins[4]}}, ins[4:0]};
      zx  = {11'd0, ins[4:0]};
      if (opc == 5'b01000)      ref_result = rs + sx;
      else if (opc == 5'b01001) ref_result = sx - rs;
      else if (opc == 5'b01010) ref_result = rs ^ zx;
      else if (opc == 5'b01011) ref_result = rs & ~zx;
      else if (opc[4:2] == 3'b101) ref_result = shift_ref(rs, opc[1:0], int'(ins[3:0]));
      else if (opc == 5'b11010) ref_result = shift_ref(rs, ins[1:0], int'(rt[3:0]));
      else if (opc == 5'b11011) begin
         case (ins[1:0])
            2'd0:    ref_result = rs + rt;
            2'd1:    ref_result = rt - rs;
            2'd2:    ref_result = rs ^ rt;
            default: ref_result = rs & ~rt;
         endcase
      end
      else if (opc == 5'b11111) ref_result = rs + rt;
      else                      ref_result = rs - rt;
   endfunction

   function automatic bit is_alu(input logic [15:0] ins);
      logic [4:0] opc;
      opc = ins[15:11];
      return (opc[4:2] == 3'b010) || (opc[4:2] == 3'b101) || (opc[4:2] == 3'b111) ||
             (opc == 5'b11010) || (opc == 5'b11011);
   endfunction

   function automatic bit ref_sign(input logic [15:0] ins);
      logic [4:0] opc;
      opc = ins[15:11];
      return (opc == 5'b01000) || (opc == 5'b01001) ||
             (opc == 5'b11011 && ins[1] == 1'b0) ||
             (opc == 5'b11100) || (opc == 5'b11101) || (opc == 5'b11110);
   endfunction

   task automatic check_entry(input string tag);
      check({tag, ".ex_valid"}, 64'(ex_valid), 64'(m_valid));
      if (m_valid) begin
         check({tag, ".alu_en"}, 64'(ex_alu_en), 64'(is_alu(m_instr)));
         if (is_alu(m_instr)) begin
            check({tag, ".A"}, 64'(A), 64'(m_rs));
            check({tag, ".sign"}, 64'(sign), 64'(ref_sign(m_instr)));
            check({tag, ".result"}, 64'(alu_eval(A, B, Cin, Op, invA, invB)),
                  64'(ref_result(m_instr, m_rs, m_rt)));
         end else begin
            check({tag, ".nop"}, {A, B, Cin, Op, invA, invB, sign},
                  {16'h0, 16'h0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0});
         end
      end
   endtask

   // One clock: drive at negedge, predict, then look at outputs at the next negedge.
   task automatic step(input string tag, input bit v, input logic [15:0] ins,
                       input logic [15:0] rs, input logic [15:0] rt,
                       input bit exr, input bit fl);
      bit rdy;
      in_valid = v; in_instr = ins; in_rs = rs; in_rt = rt; ex_ready = exr; flush = fl;
      #1;
      rdy = !m_valid || exr;
      check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
      if (fl) m_valid = 1'b0;
      else if (v && rdy) begin
         m_valid = 1'b1; m_instr = ins; m_rs = rs; m_rt = rt;
      end
      else if (exr) m_valid = 1'b0;
      @(negedge clk);
      check_entry(tag);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] w;
      logic [4:0]  opcs [10];
      opcs = '{5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10100, 5'b10111,
               5'b11010, 5'b11011, 5'b11101, 5'b11111};
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) w[15:11] = opcs[$urandom_range(0, 9)];
      return w;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; in_rs = 16'h0; in_rt = 16'h0;
      flush = 1'b0; ex_ready = 1'b0;
      m_valid = 1'b0; m_instr = 16'h0; m_rs = 16'h0; m_rt = 16'h0;
      @(negedge clk); @(negedge clk);
      check("reset.outs", {ex_valid, ex_alu_en, A, B, Cin, Op, invA, invB, sign}, 64'd0);
      check("reset.in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(negedge clk);

      // ADDI imm=5, Rs=3
      step("addi", 1'b1, 16'h4105, 16'h0003, 16'h0000, 1'b1, 1'b0);
      check("addi.fields", {A, B, Cin, Op, invA, invB, sign, ex_valid},
            {16'd3, 16'd5, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1});

      // register SUB: Rt - Rs
      step("sub", 1'b1, 16'hD801, 16'd7, 16'd10, 1'b1, 1'b0);
      check("sub.fields", {A, B, Cin, Op, invA}, {16'd7, 16'd10, 1'b1, 4'd4, 1'b1});
      check("sub.alu_out", 64'(alu_eval(A, B, Cin, Op, invA, invB)), 64'd3);

      // reset asserted mid-stream, between edges
      #2 rst = 1'b1;
      #1;
      check("rst_mid.outs", {ex_valid, ex_alu_en, A, B, Cin, Op, invA, invB, sign}, 64'd0);
      check("rst_mid.in_ready", 64'(in_ready), 64'd1);
      m_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // stall: load, hold three cycles while ID keeps offering, then release
      step("stall.load", 1'b1, 16'h5A1F, 16'h1234, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step("stall.hold", 1'b1, 16'hD802, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
      check("stall.A_kept", 64'(A), 64'h1234);
      step("stall.release", 1'b1, 16'hD802, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
      check("stall.next_A", 64'(A), 64'hAAAA);

      // flush with a held entry and a same-cycle input
      step("flush.load", 1'b1, 16'hE000, 16'h0F0F, 16'h00FF, 1'b0, 1'b0);
      step("flush", 1'b1, 16'h4101, 16'h9999, 16'h0, 1'b0, 1'b1);
      check("flush.dropped", 64'(ex_valid), 64'd0);

      // back-to-back entries including an illegal opcode
      step("b2b.0", 1'b1, 16'h1234, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      check("illegal.zero", {ex_alu_en, A, B}, 64'd0);
      for (int i = 1; i < 4; i++)
         step("b2b", 1'b1, rand_instr(), 16'($urandom), 16'($urandom), 1'b1, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), rand_instr(), 16'($urandom),
              16'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 11) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
